// File: rtl/conv_scheduler.sv
// Convolution position scheduler: walks the filter centre over every valid
// image position, waits for one allocator result per position and streams it out.
module conv_scheduler #(
  parameter int TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  cfg_width,
  input  logic [7:0]  cfg_height,
  input  logic [2:0]  cfg_filter_dim,
  input  logic [17:0] cfg_filter_bias,
  input  logic [12:0] cfg_filter_length,
  output logic [7:0]  center_x,
  output logic [7:0]  center_y,
  output logic [2:0]  filter_dim,
  output logic [17:0] filter_bias,
  output logic [12:0] filter_length,
  output logic        alloc_clear,
  input  logic        result_ready,
  input  logic [17:0] result_data,
  output logic        out_valid,
  output logic [17:0] out_data,
  output logic [15:0] out_addr,
  input  logic        out_ready,
  output logic        busy,
  output logic        done,
  output logic        err
);

  // wcnt only needs to reach TIMEOUT-1; the abort fires on the cycle it matches
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT, S_EMIT, S_DONE} state_t;

  typedef struct packed {
    logic [7:0]       width;
    logic [7:0]       height;
    logic [7:0]       rad;
    logic [7:0]       cx;
    logic [7:0]       cy;
    logic [2:0]       dim;
    logic [17:0]      bias;
    logic [12:0]      len;
    logic [15:0]      addr;
    logic [17:0]      data;
    logic             valid;
    logic             clr;
    logic             busy;
    logic             done;
    logic             err;
    logic [CNT_W-1:0] wcnt;
  } regs_t;

  state_t st_q, st_nxt;
  regs_t  r_q, r_nxt;

  logic       cfg_ok;
  logic [7:0] x_last, y_last;
  logic       at_last;

  assign cfg_ok  = cfg_filter_dim[0] &&
                   ({5'd0, cfg_filter_dim} <= cfg_width) &&
                   ({5'd0, cfg_filter_dim} <= cfg_height);
  assign x_last  = r_q.width  - 8'd1 - r_q.rad;
  assign y_last  = r_q.height - 8'd1 - r_q.rad;
  assign at_last = (r_q.cx == x_last) && (r_q.cy == y_last);

  always_comb begin
    st_nxt     = st_q;
    r_nxt      = r_q;
    r_nxt.clr  = 1'b0;
    r_nxt.done = 1'b0;
    r_nxt.err  = 1'b0;
    case (st_q)
      S_IDLE: begin
        if (start) begin
          if (cfg_ok) begin
            r_nxt.width  = cfg_width;
            r_nxt.height = cfg_height;
            r_nxt.dim    = cfg_filter_dim;
            r_nxt.bias   = cfg_filter_bias;
            r_nxt.len    = cfg_filter_length;
            r_nxt.rad    = {6'd0, cfg_filter_dim[2:1]};
            r_nxt.cx     = {6'd0, cfg_filter_dim[2:1]};
            r_nxt.cy     = {6'd0, cfg_filter_dim[2:1]};
            r_nxt.addr   = 16'd0;
            r_nxt.valid  = 1'b0;
            r_nxt.busy   = 1'b1;
            r_nxt.clr    = 1'b1;
            st_nxt       = S_LOAD;
          end else begin
            r_nxt.err = 1'b1;
          end
        end
      end
      S_LOAD: begin
        r_nxt.wcnt = '0;
        st_nxt     = S_WAIT;
      end
      S_WAIT: begin
        if (result_ready) begin
          r_nxt.data  = result_data;
          r_nxt.valid = 1'b1;
          st_nxt      = S_EMIT;
        end else if (r_q.wcnt == CNT_W'(TIMEOUT - 1)) begin
          r_nxt.err  = 1'b1;
          r_nxt.busy = 1'b0;
          st_nxt     = S_IDLE;
        end else begin
          r_nxt.wcnt = r_q.wcnt + 1'b1;
        end
      end
      S_EMIT: begin
        if (out_ready) begin
          r_nxt.valid = 1'b0;
          if (at_last) begin
            st_nxt = S_DONE;
          end else begin
            r_nxt.addr = r_q.addr + 16'd1;
            if (r_q.cx == x_last) begin
              r_nxt.cx = r_q.rad;
              r_nxt.cy = r_q.cy + 8'd1;
            end else begin
              r_nxt.cx = r_q.cx + 8'd1;
            end
            r_nxt.clr = 1'b1;
            st_nxt    = S_LOAD;
          end
        end
      end
      S_DONE: begin
        r_nxt.done = 1'b1;
        r_nxt.busy = 1'b0;
        st_nxt     = S_IDLE;
      end
      default: st_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q <= S_IDLE;
      r_q  <= '0;
    end else begin
      st_q <= st_nxt;
      r_q  <= r_nxt;
    end
  end

  assign center_x      = r_q.cx;
  assign center_y      = r_q.cy;
  assign filter_dim    = r_q.dim;
  assign filter_bias   = r_q.bias;
  assign filter_length = r_q.len;
  assign alloc_clear   = r_q.clr;
  assign out_valid     = r_q.valid;
  assign out_data      = r_q.data;
  assign out_addr      = r_q.addr;
  assign busy          = r_q.busy;
  assign done          = r_q.done;
  assign err           = r_q.err;

endmodule

// File: tb/tb_conv_scheduler.sv
// Scoreboard bench for conv_scheduler: expected positions come from a row-major
// walk of the image, expected data from what the responder handed the DUT.
module tb_conv_scheduler;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [7:0]  cfg_width, cfg_height;
  logic [2:0]  cfg_filter_dim;
  logic [17:0] cfg_filter_bias;
  logic [12:0] cfg_filter_length;
  logic [7:0]  center_x, center_y;
  logic [2:0]  filter_dim;
  logic [17:0] filter_bias;
  logic [12:0] filter_length;
  logic        alloc_clear, result_ready, out_valid, out_ready, busy, done, err;
  logic [17:0] result_data, out_data;
  logic [15:0] out_addr;

  conv_scheduler #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_width(cfg_width), .cfg_height(cfg_height),
    .cfg_filter_dim(cfg_filter_dim), .cfg_filter_bias(cfg_filter_bias),
    .cfg_filter_length(cfg_filter_length),
    .center_x(center_x), .center_y(center_y),
    .filter_dim(filter_dim), .filter_bias(filter_bias), .filter_length(filter_length),
    .alloc_clear(alloc_clear), .result_ready(result_ready), .result_data(result_data),
    .out_valid(out_valid), .out_data(out_data), .out_addr(out_addr), .out_ready(out_ready),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct { int addr; int x; int y; } pos_t;
  pos_t        pos_q[$];
  logic [17:0] data_q[$];
  int n_chk = 0, n_err = 0, n_xfer = 0;
  bit resp_en = 1'b1;
  int resp_dly = -1;
  int rdy_mode = 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // out_ready: 0 = held low, 1 = held high, otherwise random per cycle
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #2;
      case (rdy_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Allocator model: one result per alloc_clear, held one extra cycle with
  // different data so a capture outside WAIT would be visible.
  initial begin
    int d;
    result_ready = 1'b0;
    result_data  = '0;
    forever begin
      @(negedge clk);
      if (alloc_clear && resp_en) begin
        d = (resp_dly < 0) ? int'($urandom_range(0, 3)) : resp_dly;
        @(posedge clk); #1;
        repeat (d) begin @(posedge clk); #1; end
        result_ready = 1'b1;
        result_data  = 18'($urandom);
        data_q.push_back(result_data);
        @(posedge clk); #1;
        result_data = 18'($urandom);
        @(posedge clk); #1;
        result_ready = 1'b0;
      end
    end
  end

  // Monitor: a transfer happens at the next edge whenever valid&&ready here
  initial begin
    pos_t        p;
    logic [17:0] dv;
    forever begin
      @(negedge clk);
      if (alloc_clear) chk("clr_with_valid", out_valid, 0);
      if (out_valid && out_ready) begin
        n_xfer++;
        if (pos_q.size() == 0 || data_q.size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL xfer_unexpected: got addr %0d expected no transfer", out_addr);
        end else begin
          p  = pos_q.pop_front();
          dv = data_q.pop_front();
          chk("out_addr", out_addr, p.addr);
          chk("center_x", center_x, p.x);
          chk("center_y", center_y, p.y);
          chk("out_data", out_data, dv);
        end
      end
    end
  end

  task automatic build_model(input int w, input int h, input int dim);
    int r, a;
    r = dim / 2;
    a = 0;
    for (int y = r; y <= h - 1 - r; y++)
      for (int x = r; x <= w - 1 - r; x++) begin
        pos_q.push_back('{a, x, y});
        a++;
      end
  endtask

  task automatic do_start(input int w, input int h, input int dim,
                          input logic [17:0] b, input logic [12:0] l);
    @(posedge clk); #1;
    cfg_width = 8'(w); cfg_height = 8'(h); cfg_filter_dim = 3'(dim);
    cfg_filter_bias = b; cfg_filter_length = l;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_job(input int w, input int h, input int dim);
    logic [17:0] b;
    logic [12:0] l;
    bit ok;
    int cyc;
    b  = 18'($urandom);
    l  = 13'($urandom);
    ok = (dim % 2 == 1) && (dim <= w) && (dim <= h);
    if (ok) build_model(w, h, dim);
    n_xfer = 0;
    do_start(w, h, dim, b, l);
    @(negedge clk);
    if (!ok) begin
      chk("bad_cfg_err", err, 1);
      chk("bad_cfg_busy", busy, 0);
      chk("bad_cfg_clr", alloc_clear, 0);
      @(negedge clk);
      chk("bad_cfg_err_pulse", err, 0);
      chk("bad_cfg_idle", busy | alloc_clear, 0);
      return;
    end
    chk("start_busy", busy, 1);
    chk("start_clr", alloc_clear, 1);
    chk("start_cx", center_x, dim / 2);
    chk("start_cy", center_y, dim / 2);
    chk("start_addr", out_addr, 0);
    chk("latch_dim", filter_dim, dim);
    chk("latch_bias", filter_bias, b);
    chk("latch_len", filter_length, l);
    cyc = 0;
    while (!done && cyc < 3000) begin @(negedge clk); cyc++; end
    if (!done) begin
      n_chk++; n_err++;
      $display("FAIL done_timeout: got no done after %0d cycles expected done", cyc);
      return;
    end
    chk("done_busy", busy, 0);
    chk("xfer_count", n_xfer, (w - dim + 1) * (h - dim + 1));
    chk("model_drained", pos_q.size(), 0);
    @(negedge clk);
    chk("done_pulse", done, 0);
  endtask

  initial begin
    logic [17:0] sd;
    logic [15:0] sa;
    int cyc;
    rst = 1'b1; start = 1'b0;
    cfg_width = '0; cfg_height = '0; cfg_filter_dim = '0;
    cfg_filter_bias = '0; cfg_filter_length = '0;
    @(negedge clk);
    chk("rst_outputs", {center_x, center_y, filter_dim, filter_bias, filter_length,
                        alloc_clear, out_valid, busy, done, err}, 0);
    chk("rst_data_addr", {out_data, out_addr}, 0);
    #2 rst = 1'b0;

    // 5x5 / 3x3 filter, fixed result latency, out_ready high
    rdy_mode = 1; resp_dly = 1;
    run_job(5, 5, 3);

    // Back-pressure: out_ready low for 5 EMIT cycles
    rdy_mode = 0;
    fork
      run_job(5, 3, 3);
      begin
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (!out_valid && cyc < 100);
        chk("stall_valid_seen", out_valid, 1);
        sd = out_data; sa = out_addr;
        repeat (4) begin
          @(negedge clk);
          chk("stall_valid", out_valid, 1);
          chk("stall_data", out_data, sd);
          chk("stall_addr", out_addr, sa);
          chk("stall_clr", alloc_clear, 0);
        end
        @(posedge clk); #1 rdy_mode = 1;
        @(negedge clk);
        chk("stall_release", {out_valid, out_ready}, 2'b11);
        @(negedge clk);
        chk("stall_xfer_once", out_valid, 0);
      end
    join

    // Invalid configurations
    run_job(8, 8, 4);
    run_job(5, 8, 7);
    run_job(6, 6, 0);

    // Timeout: no allocator response
    resp_en = 1'b0;
    do_start(4, 4, 3, 18'd5, 13'd5);
    @(negedge clk);
    chk("to_load_clr", alloc_clear, 1);
    for (int k = 1; k <= TO; k++) begin
      @(negedge clk);
      chk("to_wait_err", err, 0);
      chk("to_wait_valid", out_valid, 0);
      chk("to_wait_busy", busy, 1);
    end
    @(negedge clk);
    chk("to_err", err, 1);
    chk("to_busy", busy, 0);
    chk("to_valid", out_valid, 0);
    @(negedge clk);
    chk("to_err_pulse", err, 0);
    resp_en = 1'b1;

    // Reset during EMIT of output 4
    resp_dly = -1; rdy_mode = 1;
    build_model(5, 5, 3);
    do_start(5, 5, 3, 18'h3ffff, 13'h1fff);
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!(out_valid && out_addr == 16'd4) && cyc < 500);
    chk("rst_reached_addr4", out_addr, 4);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_outputs", {center_x, center_y, filter_dim, filter_bias, filter_length,
                              alloc_clear, out_valid, busy, done, err}, 0);
    chk("async_rst_data_addr", {out_data, out_addr}, 0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    pos_q.delete(); data_q.delete();
    repeat (4) begin
      @(negedge clk);
      chk("abandoned_quiet", {out_valid, done, err, busy, alloc_clear}, 0);
    end
    run_job(5, 5, 3);

    // start pulse and cfg change mid-job are ignored
    fork
      run_job(5, 4, 3);
      begin
        repeat (6) @(posedge clk);
        #1;
        start = 1'b1; cfg_width = 8'd8; cfg_height = 8'd8; cfg_filter_dim = 3'd5;
        @(posedge clk); #1 start = 1'b0;
      end
    join
    chk("midjob_dim_kept", filter_dim, 3);

    // Randomized jobs, including invalid shapes and random back-pressure
    rdy_mode = 2;
    for (int i = 0; i < 8; i++) begin
      int w, h, d;
      w = int'($urandom_range(1, 8));
      h = int'($urandom_range(1, 8));
      d = int'($urandom_range(0, 6));
      run_job(w, h, d);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
